ula_multiciclo: RTL and testbench

Parametrised successor to the datapath ALU (ULA): same 4-bit ALU-control encoding, generalised to `WIDTH`-bit operands, extended with logic, shift and compare ops plus iterative multiply and unsigned divide/remainder, and with a registered branch-compare flag. It sits between the operand muxes and the write-back mux. All results are registered behind a start/busy/done handshake, so the control FSM can stall on multi-cycle ops.

---
 rtl/ula_multiciclo_if.sv | 25 ++
 rtl/ula_multiciclo.sv | 139 +++++++++++++
 tb/tb_ula_multiciclo.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ula_multiciclo_if.sv
// rtl/ula_multiciclo_if.sv - request/result bundle between control FSM and ula_multiciclo
interface ula_multiciclo_if #(
    parameter int WIDTH = 64
);
    logic             start;
    logic [3:0]       sinal;
    logic             branch;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] soma;
    logic             flag;
    logic             busy;
    logic             done;

    modport master (
        output start, sinal, branch, funct3, a, b,
        input  soma, flag, busy, done
    );

    modport slave (
        input  start, sinal, branch, funct3, a, b,
        output soma, flag, busy, done
    );
endinterface

// File: rtl/ula_multiciclo.sv
// rtl/ula_multiciclo.sv - multi-cycle ALU: single-cycle logic/arith/shift/compare, iterative mul and divu
module ula_multiciclo #(
    parameter int WIDTH = 64
) (
    input  logic              clock,
    input  logic              reset,
    ula_multiciclo_if.slave   bus
);
    localparam int SH = $clog2(WIDTH);
    localparam logic [SH-1:0] LAST = SH'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [SH-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   soma_q, soma_d;
    logic               flag_q, flag_d;
    logic               done_q, done_d;

    logic [SH-1:0]      shamt;
    logic               eq, lts, ltu, is_multi, flag_calc;
    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH:0]     mul_sum, trial, diff;
    logic [2*WIDTH-1:0] mul_next, div_next, iter_next;

    assign shamt    = bus.b[SH-1:0];
    assign eq       = (bus.a == bus.b);
    assign lts      = ($signed(bus.a) < $signed(bus.b));
    assign ltu      = (bus.a < bus.b);
    assign is_multi = (bus.sinal >= 4'b1010) && (bus.sinal <= 4'b1101);

    // acc holds {high, low}: product accumulator for mul, {remainder, quotient} for div
    assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    assign mul_next  = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    assign trial     = acc_q[2*WIDTH-1:WIDTH-1];
    assign diff      = trial - {1'b0, opb_q};
    assign div_next  = diff[WIDTH] ? {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                   : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign iter_next = op_q[1] ? mul_next : div_next;

    always_comb begin
        alu_res = bus.a - bus.b;
        case (bus.sinal)
            4'b0000: alu_res = bus.a & bus.b;
            4'b0001: alu_res = bus.a | bus.b;
            4'b0010: alu_res = bus.a + bus.b;
            4'b0011: alu_res = bus.a ^ bus.b;
            4'b0100: alu_res = bus.a << shamt;
            4'b0101: alu_res = bus.a >> shamt;
            4'b1001: alu_res = $signed(bus.a) >>> shamt;
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, lts};
            4'b1000: alu_res = {{(WIDTH-1){1'b0}}, ltu};
            default: alu_res = bus.a - bus.b;
        endcase

        flag_calc = 1'b0;
        if (bus.branch) begin
            case (bus.funct3)
                3'b000:  flag_calc = eq;
                3'b001:  flag_calc = !eq;
                3'b100:  flag_calc = lts;
                3'b101:  flag_calc = !lts;
                3'b110:  flag_calc = ltu;
                3'b111:  flag_calc = !ltu;
                default: flag_calc = 1'b0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        soma_d  = soma_q;
        flag_d  = flag_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    flag_d = flag_calc;
                    if (is_multi) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        // sinal[1] selects mul vs div, sinal[0] selects high vs low half
                        op_d    = bus.sinal[1:0];
                        opb_d   = bus.b;
                        acc_d   = {{WIDTH{1'b0}}, bus.a};
                    end else begin
                        soma_d = alu_res;
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                acc_d = iter_next;
                cnt_d = cnt_q + SH'(1);
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    soma_d  = op_q[0] ? iter_next[2*WIDTH-1:WIDTH] : iter_next[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            acc_q   <= '0;
            opb_q   <= '0;
            soma_q  <= '0;
            flag_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            opb_q   <= opb_d;
            soma_q  <= soma_d;
            flag_q  <= flag_d;
            done_q  <= done_d;
        end
    end

    assign bus.soma = soma_q;
    assign bus.flag = flag_q;
    assign bus.busy = (state_q == RUN);
    assign bus.done = done_q;
endmodule

// File: tb/tb_ula_multiciclo.sv
// tb/tb_ula_multiciclo.sv - scoreboard bench for ula_multiciclo at WIDTH 64 and 8
module tb_ula_multiciclo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ula_multiciclo_if #(.WIDTH(64)) bus ();
    ula_multiciclo_if #(.WIDTH(8))  bus8 ();

    ula_multiciclo #(.WIDTH(64)) dut  (.clock(clk), .reset(rst), .bus(bus));
    ula_multiciclo #(.WIDTH(8))  dut8 (.clock(clk), .reset(rst), .bus(bus8));

    typedef struct packed {
        logic [63:0] soma;
        logic        flag;
    } exp_t;

    exp_t sb[$];
    exp_t sb8[$];
    exp_t mon_e;
    exp_t mon_e8;
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [63:0] ref_res(input logic [3:0] s, input logic [63:0] x, input logic [63:0] y);
        logic [127:0] p;
        logic signed [63:0] sx;
        int sh;
        p  = {64'd0, x} * {64'd0, y};
        sx = x;
        sh = int'(y[5:0]);
        case (s)
            4'd0:  return x & y;
            4'd1:  return x | y;
            4'd2:  return x + y;
            4'd3:  return x ^ y;
            4'd4:  return x << sh;
            4'd5:  return x >> sh;
            4'd9:  return sx >>> sh;
            4'd7:  return ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
            4'd8:  return (x < y) ? 64'd1 : 64'd0;
            4'd10: return p[63:0];
            4'd11: return p[127:64];
            4'd12: return (y == 0) ? {64{1'b1}} : x / y;
            4'd13: return (y == 0) ? x : x % y;
            default: return x - y;
        endcase
    endfunction

    function automatic logic ref_flag(input logic br, input logic [2:0] f3, input logic [63:0] x, input logic [63:0] y);
        if (!br) return 1'b0;
        case (f3)
            3'd0: return x == y;
            3'd1: return x != y;
            3'd4: return $signed(x) < $signed(y);
            3'd5: return $signed(x) >= $signed(y);
            3'd6: return x < y;
            3'd7: return x >= y;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] ref8(input logic [3:0] s, input logic [7:0] x, input logic [7:0] y);
        logic [15:0] p;
        p = {8'd0, x} * {8'd0, y};
        case (s)
            4'd2:  return x + y;
            4'd10: return p[7:0];
            4'd11: return p[15:8];
            4'd12: return (y == 0) ? 8'hFF : x / y;
            4'd13: return (y == 0) ? x : x % y;
            default: return x - y;
        endcase
    endfunction

    task automatic issue(input logic [3:0] s, input logic [63:0] x, input logic [63:0] y,
                         input logic br, input logic [2:0] f3);
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) check("issue_timeout", 64'd1, 64'd0);
        bus.start = 1'b1; bus.sinal = s; bus.a = x; bus.b = y; bus.branch = br; bus.funct3 = f3;
        @(posedge clk);
        sb.push_back('{soma: ref_res(s, x, y), flag: ref_flag(br, f3, x, y)});
        #1 bus.start = 1'b0;
    endtask

    task automatic issue8(input logic [3:0] s, input logic [7:0] x, input logic [7:0] y);
        int n = 0;
        @(negedge clk);
        while (bus8.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus8.busy) check("issue8_timeout", 64'd1, 64'd0);
        bus8.start = 1'b1; bus8.sinal = s; bus8.a = x; bus8.b = y; bus8.branch = 1'b0; bus8.funct3 = 3'd0;
        @(posedge clk);
        sb8.push_back('{soma: {56'd0, ref8(s, x, y)}, flag: 1'b0});
        #1 bus8.start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((bus.busy || bus8.busy || sb.size() != 0 || sb8.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain_sb", 64'(sb.size()), 64'd0);
        check("drain_sb8", 64'(sb8.size()), 64'd0);
    endtask

    initial begin
        int lat, bcnt;
        logic [3:0] s;
        logic [63:0] x, y;
        logic [3:0] ops8 [6];
        ops8 = '{4'd2, 4'd6, 4'd10, 4'd11, 4'd12, 4'd13};

        bus.start = 0; bus.sinal = 0; bus.a = 0; bus.b = 0; bus.branch = 0; bus.funct3 = 0;
        bus8.start = 0; bus8.sinal = 0; bus8.a = 0; bus8.b = 0; bus8.branch = 0; bus8.funct3 = 0;

        fork
            forever begin
                @(negedge clk);
                if (!rst && bus.done) begin
                    if (sb.size() == 0) check("unexpected_done", 64'd1, 64'd0);
                    else begin
                        mon_e = sb.pop_front();
                        check("soma", bus.soma, mon_e.soma);
                        check("flag", {63'd0, bus.flag}, {63'd0, mon_e.flag});
                    end
                end
                if (!rst && bus8.done) begin
                    if (sb8.size() == 0) check("unexpected_done8", 64'd1, 64'd0);
                    else begin
                        mon_e8 = sb8.pop_front();
                        check("soma8", {56'd0, bus8.soma}, mon_e8.soma);
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        check("rst_soma", bus.soma, 64'd0);
        check("rst_flag", {63'd0, bus.flag}, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        rst = 1'b0;

        issue(4'd2, 64'd45, 64'd11, 1'b0, 3'd0);
        @(negedge clk);
        check("add_done", {63'd0, bus.done}, 64'd1);
        check("add_soma", bus.soma, 64'd56);
        @(negedge clk);
        check("add_done_pulse", {63'd0, bus.done}, 64'd0);
        issue(4'd6, 64'd14, 64'd45, 1'b0, 3'd0);
        @(negedge clk);
        check("sub_soma", bus.soma, -64'sd31);

        issue(4'd7, '1, 64'd1, 1'b1, 3'b100);
        issue(4'd8, '1, 64'd1, 1'b1, 3'b110);
        issue(4'd2, '1, 64'd1, 1'b1, 3'b111);
        issue(4'd2, 64'd62, 64'd62, 1'b1, 3'b000);
        issue(4'd2, 64'd62, 64'd62, 1'b1, 3'b001);
        issue(4'd2, 64'd62, 64'd62, 1'b0, 3'b000);
        issue(4'd9, 64'h8000_0000_0000_0000, 64'd4, 1'b0, 3'd0);
        issue(4'd4, 64'h0000_0000_0000_0003, 64'd65, 1'b0, 3'd0);
        issue(4'd14, 64'd9, 64'd2, 1'b0, 3'd0);
        issue(4'd15, 64'd2, 64'd9, 1'b0, 3'd0);

        issue(4'd10, '1, '1, 1'b0, 3'd0);
        lat = 0; bcnt = 0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (bus.busy) bcnt++;
            if (bus.done) break;
        end
        check("mul_latency", 64'(lat), 64'd65);
        check("mul_busy_cycles", 64'(bcnt), 64'd64);
        issue(4'd11, '1, '1, 1'b0, 3'd0);
        issue(4'd12, 64'd100, 64'd7, 1'b0, 3'd0);
        issue(4'd13, 64'd100, 64'd7, 1'b0, 3'd0);
        issue(4'd12, 64'd5, 64'd0, 1'b0, 3'd0);
        issue(4'd13, 64'd5, 64'd0, 1'b0, 3'd0);

        issue(4'd12, 64'hdead_beef_1234_5678, 64'd13, 1'b1, 3'b001);
        repeat (10) @(negedge clk);
        bus.start = 1'b1; bus.sinal = 4'd2; bus.a = 64'd1; bus.b = 64'd1; bus.branch = 1'b0;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;

        for (int i = 0; i < 150; i++) begin
            s = 4'($urandom_range(15));
            x = {$urandom, $urandom};
            case ($urandom_range(3))
                0:       y = 64'($urandom_range(70));
                1:       y = x;
                default: y = {$urandom, $urandom};
            endcase
            issue(s, x, y, 1'($urandom_range(1)), 3'($urandom_range(7)));
        end
        drain();

        issue(4'd2, 64'd3, 64'd4, 1'b0, 3'd0);
        issue(4'd10, {$urandom, $urandom}, {$urandom, $urandom}, 1'b1, 3'b001);
        @(negedge clk);
        check("run_holds_soma", bus.soma, 64'd7);
        check("run_busy", {63'd0, bus.busy}, 64'd1);
        repeat (28) @(negedge clk);
        rst = 1'b1;
        bus.start = 1'b1; bus.sinal = 4'd2;
        @(posedge clk);
        #1;
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_soma", bus.soma, 64'd0);
        check("abort_flag", {63'd0, bus.flag}, 64'd0);
        check("abort_done", {63'd0, bus.done}, 64'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        repeat (80) @(negedge clk);

        issue8(4'd2, 8'd200, 8'd100);
        @(negedge clk);
        check("add8_soma", {56'd0, bus8.soma}, 64'd44);
        for (int i = 0; i < 40; i++) begin
            issue8(ops8[$urandom_range(5)], 8'($urandom), 8'($urandom_range(255) >> $urandom_range(7)));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
